// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared types and defaults for the register-bank write-back arbiter.
package regbank_wb_arbiter_pkg;

  localparam int unsigned DefNumReq   = 3;
  localparam int unsigned DefBankW    = 5;
  localparam int unsigned DefRegWidth = 32;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// Write-back request bus: one valid/ready pair plus packed dest index and data per source.
interface regbank_wb_arbiter_if
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DefNumReq,
  parameter int unsigned BANK_WIDTH     = DefBankW,
  parameter int unsigned REGISTER_WIDTH = DefRegWidth
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*BANK_WIDTH-1:0]     req_rd_sel;
  logic [NUM_REQ*REGISTER_WIDTH-1:0] req_rd_data;

  modport master (
    output req_valid,
    output req_rd_sel,
    output req_rd_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd_sel,
    input  req_rd_data,
    output req_ready
  );

endinterface

// File: rtl/regbank_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_gnt_idx
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    // Scan farthest offset first so the nearest requester overwrites earlier picks.
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(i_ptr) + (N - 1 - k)) % N;
      if (i_req[idx]) begin
        o_gnt      = '0;
        o_gnt[idx] = 1'b1;
        o_gnt_idx  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Arbitrates write-back sources onto the bank write port, with a per-register busy
// scoreboard; nothing is accepted until the bank has finished its clear sweep.
module regbank_wb_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DefNumReq,
  parameter int unsigned BANK_WIDTH     = DefBankW,
  parameter int unsigned REGISTER_WIDTH = DefRegWidth,
  localparam int unsigned IdxW = $clog2(NUM_REQ),
  localparam int unsigned Size = 2 ** BANK_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_bank_ready,
  regbank_wb_arbiter_if.slave       wb,
  output logic                      o_reg_w,
  output logic [BANK_WIDTH-1:0]     o_rd_sel,
  output logic [REGISTER_WIDTH-1:0] o_rd_data,
  output logic [IdxW-1:0]           o_grant_id,
  input  logic                      i_claim_valid,
  input  logic [BANK_WIDTH-1:0]     i_claim_sel,
  output logic                      o_claim_ready,
  output logic [Size-1:0]           o_busy
);

  state_e                    r_state, w_state_d;
  logic [IdxW-1:0]           r_rr_ptr, w_rr_ptr_d;
  logic                      r_reg_w, w_reg_w_d;
  logic [BANK_WIDTH-1:0]     r_rd_sel, w_rd_sel_d;
  logic [REGISTER_WIDTH-1:0] r_rd_data, w_rd_data_d;
  logic [IdxW-1:0]           r_grant_id, w_grant_id_d;
  logic [Size-1:0]           r_busy, w_busy_d;

  logic [NUM_REQ-1:0]        w_gnt;
  logic [IdxW-1:0]           w_gnt_idx;
  logic                      w_run, w_leave, w_hs, w_claim_hs;
  logic [BANK_WIDTH-1:0]     w_sel;
  logic [REGISTER_WIDTH-1:0] w_data;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .i_req     (wb.req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_run   = (r_state == StRun);
  assign w_leave = w_run && !i_bank_ready;
  assign w_hs    = w_run && (|wb.req_valid);
  assign w_sel   = wb.req_rd_sel[32'(w_gnt_idx) * BANK_WIDTH +: BANK_WIDTH];
  assign w_data  = wb.req_rd_data[32'(w_gnt_idx) * REGISTER_WIDTH +: REGISTER_WIDTH];

  assign wb.req_ready  = w_run ? w_gnt : '0;
  assign o_claim_ready = w_run && ((i_claim_sel == '0) || !r_busy[i_claim_sel]);
  assign w_claim_hs    = i_claim_valid && o_claim_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StInit:  if (i_bank_ready) w_state_d = StRun;
      StRun:   if (!i_bank_ready) w_state_d = StInit;
      default: w_state_d = StInit;
    endcase
  end

  always_comb begin
    w_rr_ptr_d   = r_rr_ptr;
    w_reg_w_d    = 1'b0;
    w_rd_sel_d   = r_rd_sel;
    w_rd_data_d  = r_rd_data;
    w_grant_id_d = r_grant_id;
    if (w_hs) begin
      w_rr_ptr_d = IdxW'(wrap_inc(32'(w_gnt_idx), NUM_REQ));
    end
    // A write accepted while the bank is dropping out is discarded.
    if (w_hs && !w_leave) begin
      w_reg_w_d    = (w_sel != '0);
      w_rd_sel_d   = w_sel;
      w_rd_data_d  = w_data;
      w_grant_id_d = w_gnt_idx;
    end
  end

  always_comb begin
    w_busy_d = r_busy;
    if (r_reg_w) w_busy_d[r_rd_sel] = 1'b0;
    if (w_claim_hs && (i_claim_sel != '0)) w_busy_d[i_claim_sel] = 1'b1;
    if (w_leave) w_busy_d = '0;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StInit;
      r_rr_ptr   <= '0;
      r_reg_w    <= 1'b0;
      r_rd_sel   <= '0;
      r_rd_data  <= '0;
      r_grant_id <= '0;
      r_busy     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_reg_w    <= w_reg_w_d;
      r_rd_sel   <= w_rd_sel_d;
      r_rd_data  <= w_rd_data_d;
      r_grant_id <= w_grant_id_d;
      r_busy     <= w_busy_d;
    end
  end

  assign o_reg_w    = r_reg_w;
  assign o_rd_sel   = r_rd_sel;
  assign o_rd_data  = r_rd_data;
  assign o_grant_id = r_grant_id;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: init hold-off, fairness, x0, scoreboard, reset.
module tb_regbank_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        bank_ready;
  logic        reg_w;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
  logic [1:0]  grant_id;
  logic        claim_valid;
  logic [4:0]  claim_sel;
  logic        claim_ready;
  logic [31:0] busy;

  int n_checks = 0;
  int n_errors = 0;

  regbank_wb_arbiter_if #(.NUM_REQ(3), .BANK_WIDTH(5), .REGISTER_WIDTH(32)) bus ();

  regbank_wb_arbiter #(
    .NUM_REQ        (3),
    .BANK_WIDTH     (5),
    .REGISTER_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_bank_ready  (bank_ready),
    .wb            (bus),
    .o_reg_w       (reg_w),
    .o_rd_sel      (rd_sel),
    .o_rd_data     (rd_data),
    .o_grant_id    (grant_id),
    .i_claim_valid (claim_valid),
    .i_claim_sel   (claim_sel),
    .o_claim_ready (claim_ready),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] sel, input logic [31:0] data);
    bus.req_rd_sel[i*5 +: 5]   = sel;
    bus.req_rd_data[i*32 +: 32] = data;
  endtask

  task automatic default_srcs();
    for (int i = 0; i < 3; i++) set_src(i, 5'(10 + i), 32'hA000_0000 + 32'(i));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bank_ready = 1'b0; claim_valid = 1'b0; claim_sel = '0;
    bus.req_valid = '0;
    default_srcs();
    #1;
    n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL reset_reg_w got=%b exp=0", reg_w); end
    n_checks++; if (rd_sel !== 5'd0) begin n_errors++; $display("FAIL reset_rd_sel got=%0d exp=0", rd_sel); end
    n_checks++; if (rd_data !== 32'd0) begin n_errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    n_checks++; if (busy !== 32'd0) begin n_errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_init();
    bus.req_valid = 3'b111;
    for (int c = 0; c < 33; c++) begin
      step();
      n_checks++; if (bus.req_ready !== 3'b000) begin n_errors++; $display("FAIL init_req_ready c=%0d got=%b exp=000", c, bus.req_ready); end
      n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL init_reg_w c=%0d got=%b exp=0", c, reg_w); end
    end
    claim_sel = 5'd4;
    #1;
    n_checks++; if (claim_ready !== 1'b0) begin n_errors++; $display("FAIL init_claim_ready got=%b exp=0", claim_ready); end
    bank_ready = 1'b1;
    step();
    n_checks++; if (bus.req_ready !== 3'b001) begin n_errors++; $display("FAIL init_first_grant got=%b exp=001", bus.req_ready); end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_rdy;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 3'b001 << (k % 3);
      n_checks++; if (bus.req_ready !== exp_rdy) begin n_errors++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); end
      step();
      n_checks++; if (reg_w !== 1'b1) begin n_errors++; $display("FAIL fair_reg_w k=%0d got=%b exp=1", k, reg_w); end
      n_checks++; if (rd_sel !== 5'(10 + k % 3)) begin n_errors++; $display("FAIL fair_rd_sel k=%0d got=%0d exp=%0d", k, rd_sel, 10 + k % 3); end
      n_checks++; if (rd_data !== 32'hA000_0000 + 32'(k % 3)) begin n_errors++; $display("FAIL fair_rd_data k=%0d got=%h", k, rd_data); end
      n_checks++; if (grant_id !== 2'(k % 3)) begin n_errors++; $display("FAIL fair_grant_id k=%0d got=%0d exp=%0d", k, grant_id, k % 3); end
    end
    bus.req_valid = '0;
    step();
    n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL fair_idle_reg_w got=%b exp=0", reg_w); end
    n_checks++; if (rd_sel !== 5'd12) begin n_errors++; $display("FAIL fair_idle_hold got=%0d exp=12", rd_sel); end
  endtask

  task automatic test_x0();
    set_src(1, 5'd0, 32'hDEAD_BEEF);
    bus.req_valid = 3'b010;
    #1;
    n_checks++; if (bus.req_ready !== 3'b010) begin n_errors++; $display("FAIL x0_ready got=%b exp=010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL x0_reg_w got=%b exp=0", reg_w); end
    n_checks++; if (grant_id !== 2'd1) begin n_errors++; $display("FAIL x0_grant_id got=%0d exp=1", grant_id); end
    n_checks++; if (busy !== 32'd0) begin n_errors++; $display("FAIL x0_busy got=%h exp=0", busy); end
    step();
    n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL x0_reg_w_after got=%b exp=0", reg_w); end
    default_srcs();
  endtask

  task automatic test_scoreboard();
    claim_sel = 5'd5; claim_valid = 1'b1;
    #1;
    n_checks++; if (claim_ready !== 1'b1) begin n_errors++; $display("FAIL sb_claim_ready got=%b exp=1", claim_ready); end
    step();
    claim_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 32'h0000_0020) begin n_errors++; $display("FAIL sb_busy_set got=%h exp=00000020", busy); end
    n_checks++; if (claim_ready !== 1'b0) begin n_errors++; $display("FAIL sb_claim_blocked got=%b exp=0", claim_ready); end
    set_src(2, 5'd5, 32'h0000_1234);
    bus.req_valid = 3'b100;
    #1;
    n_checks++; if (bus.req_ready !== 3'b100) begin n_errors++; $display("FAIL sb_req_ready got=%b exp=100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    n_checks++; if (reg_w !== 1'b1) begin n_errors++; $display("FAIL sb_reg_w got=%b exp=1", reg_w); end
    n_checks++; if (rd_sel !== 5'd5) begin n_errors++; $display("FAIL sb_rd_sel got=%0d exp=5", rd_sel); end
    n_checks++; if (rd_data !== 32'h0000_1234) begin n_errors++; $display("FAIL sb_rd_data got=%h exp=00001234", rd_data); end
    n_checks++; if (busy !== 32'h0000_0020) begin n_errors++; $display("FAIL sb_busy_hold got=%h exp=00000020", busy); end
    step();
    n_checks++; if (busy !== 32'd0) begin n_errors++; $display("FAIL sb_busy_clear got=%h exp=0", busy); end
    n_checks++; if (claim_ready !== 1'b1) begin n_errors++; $display("FAIL sb_claim_free got=%b exp=1", claim_ready); end
    default_srcs();
  endtask

  task automatic test_simultaneous();
    claim_sel = 5'd3; claim_valid = 1'b1;
    step();
    claim_valid = 1'b0;
    n_checks++; if (busy !== 32'h0000_0008) begin n_errors++; $display("FAIL sim_busy3 got=%h exp=00000008", busy); end
    set_src(0, 5'd3, 32'h0000_3333);
    bus.req_valid = 3'b001;
    step();
    bus.req_valid = '0;
    n_checks++; if (reg_w !== 1'b1 || rd_sel !== 5'd3) begin n_errors++; $display("FAIL sim_commit3 got=%b/%0d exp=1/3", reg_w, rd_sel); end
    claim_sel = 5'd7; claim_valid = 1'b1;
    #1;
    n_checks++; if (claim_ready !== 1'b1) begin n_errors++; $display("FAIL sim_claim7_ready got=%b exp=1", claim_ready); end
    step();
    claim_valid = 1'b0;
    n_checks++; if (busy !== 32'h0000_0080) begin n_errors++; $display("FAIL sim_busy got=%h exp=00000080", busy); end
    // Write to a register nobody claimed: written, scoreboard untouched.
    set_src(1, 5'd9, 32'h0000_9999);
    bus.req_valid = 3'b010;
    step();
    bus.req_valid = '0;
    n_checks++; if (reg_w !== 1'b1 || rd_sel !== 5'd9) begin n_errors++; $display("FAIL unsb_write got=%b/%0d exp=1/9", reg_w, rd_sel); end
    step();
    n_checks++; if (busy !== 32'h0000_0080) begin n_errors++; $display("FAIL unsb_busy got=%h exp=00000080", busy); end
    default_srcs();
  endtask

  task automatic test_reset_midop();
    bus.req_valid = 3'b111;
    step();
    step();
    n_checks++; if (reg_w !== 1'b1 || rd_sel !== 5'd10 || grant_id !== 2'd0) begin
      n_errors++; $display("FAIL burst_pre got=%b/%0d/%0d exp=1/10/0", reg_w, rd_sel, grant_id);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL rst_mid_reg_w got=%b exp=0", reg_w); end
    n_checks++; if (busy !== 32'd0) begin n_errors++; $display("FAIL rst_mid_busy got=%h exp=0", busy); end
    n_checks++; if (rd_sel !== 5'd0 || rd_data !== 32'd0 || grant_id !== 2'd0) begin
      n_errors++; $display("FAIL rst_mid_regs got=%0d/%h/%0d exp=0/0/0", rd_sel, rd_data, grant_id);
    end
    n_checks++; if (bus.req_ready !== 3'b000) begin n_errors++; $display("FAIL rst_mid_ready got=%b exp=000", bus.req_ready); end
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (bus.req_ready !== 3'b001) begin n_errors++; $display("FAIL rst_ptr got=%b exp=001", bus.req_ready); end
    claim_sel = 5'd6; claim_valid = 1'b1;
    step();
    claim_valid = 1'b0;
    bank_ready = 1'b0;
    n_checks++; if (reg_w !== 1'b1 || busy !== 32'h0000_0040) begin
      n_errors++; $display("FAIL drop_pre got=%b/%h exp=1/00000040", reg_w, busy);
    end
    step();
    n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL drop_reg_w got=%b exp=0", reg_w); end
    n_checks++; if (busy !== 32'd0) begin n_errors++; $display("FAIL drop_busy got=%h exp=0", busy); end
    n_checks++; if (bus.req_ready !== 3'b000 || claim_ready !== 1'b0) begin
      n_errors++; $display("FAIL drop_init got=%b/%b exp=000/0", bus.req_ready, claim_ready);
    end
    step();
    n_checks++; if (reg_w !== 1'b0) begin n_errors++; $display("FAIL drop_reg_w_after got=%b exp=0", reg_w); end
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_fairness();
    test_x0();
    test_scoreboard();
    test_simultaneous();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
